// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 4-digit BCD scan driver.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = NUM_DIGITS * DIGIT_W;
    localparam int PWM_STEPS  = 8;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    // Active-low anode select, indexed by digit position.
    localparam logic [NUM_DIGITS-1:0][NUM_DIGITS-1:0] AN_SEL = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
    localparam logic [NUM_DIGITS-1:0] AN_ALL = 4'b0000;

    typedef struct packed {
        logic                  valid;
        logic [BCD_W-1:0]      value;
    } pend_t;

    typedef struct packed {
        logic                  lt;
        logic                  rbi;
        logic                  bi;
        logic [NUM_DIGITS-1:0] an_n;
        logic [DIGIT_W-1:0]    bcd;
    } drive_t;

    localparam drive_t DRV_RST = '{lt: 1'b1, rbi: 1'b1, bi: 1'b0, an_n: AN_OFF, bcd: '0};

    // True when the digit at idx and every more-significant digit is zero.
    function automatic logic lz_blank(input logic [BCD_W-1:0] value, input digit_idx_t idx);
        logic blank;
        blank = (idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && value[DIGIT_W*i +: DIGIT_W] != '0) blank = 1'b0;
        end
        return blank;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot prescaler: terminal-count strobe plus the brightness on-window compare.
module scan_timer
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] bright,
    output logic       tc,
    output logic       on_win
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic [CW:0]   thr;

    always_ff @(posedge clk) begin
        if (rst)     cnt <= '0;
        else if (tc) cnt <= '0;
        else         cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CW'(CLK_DIV - 1));

    // Extra bit so bright=7 reaches CLK_DIV and covers the whole slot.
    assign thr    = (CW+1)'((int'(bright) + 1) * (CLK_DIV / PWM_STEPS));
    assign on_win = ({1'b0, cnt} < thr);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed BCD scan driver feeding an external BCD-to-7-segment
// decoder, with frame-synchronous value commit, dimming and lamp test.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BCD_W-1:0]      bcd_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  lamp_test,
    input  logic [2:0]            bright,
    output logic                  load_ack,
    output logic                  D,
    output logic                  C,
    output logic                  B,
    output logic                  A,
    output logic                  LT,
    output logic                  RBI,
    output logic                  BI,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame
);

    logic             tc;
    logic             on_win;
    logic             boundary;
    digit_idx_t       idx;
    logic [BCD_W-1:0] disp;
    pend_t            pend;
    drive_t           drv;
    drive_t           drv_d;

    scan_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .bright (bright),
        .tc     (tc),
        .on_win (on_win)
    );

    assign boundary = tc && (idx == '0);

    always_ff @(posedge clk) begin
        if (rst)     idx <= digit_idx_t'(NUM_DIGITS - 1);
        else if (tc) idx <= idx - 1'b1;
    end

    // A load in the commit cycle lands after the commit, so the flag stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            disp     <= '0;
            load_ack <= 1'b0;
            frame    <= 1'b0;
        end else begin
            load_ack <= boundary && pend.valid;
            frame    <= boundary;
            if (boundary && pend.valid) begin
                disp       <= pend.value;
                pend.valid <= 1'b0;
            end
            if (load) begin
                pend.value <= bcd_in;
                pend.valid <= 1'b1;
            end
        end
    end

    always_comb begin
        drv_d      = DRV_RST;
        drv_d.bcd  = disp[DIGIT_W*idx +: DIGIT_W];
        drv_d.rbi  = ~(blank_lz && lz_blank(disp, idx));
        if (on_win) begin
            drv_d.an_n = AN_SEL[idx];
            drv_d.bi   = 1'b1;
        end
        if (lamp_test) begin
            drv_d.lt   = 1'b0;
            drv_d.bi   = 1'b1;
            drv_d.an_n = AN_ALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) drv <= DRV_RST;
        else     drv <= drv_d;
    end

    assign {D, C, B, A} = drv.bcd;
    assign LT           = drv.lt;
    assign RBI          = drv.rbi;
    assign BI           = drv.bi;
    assign an_n         = drv.an_n;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver at CLK_DIV=8: stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load, blank_lz, lamp_test;
    logic [2:0]  bright;
    logic        load_ack, D, C, B, A, LT, RBI, BI, frame;
    logic [3:0]  an_n;
    logic [12:0] o;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    localparam logic [12:0] M_ACK = 13'h1000;
    localparam logic [12:0] M_FRM = 13'h0800;
    localparam logic [12:0] M_LT  = 13'h0400;
    localparam logic [12:0] M_RBI = 13'h0200;
    localparam logic [12:0] M_BI  = 13'h0100;
    localparam logic [12:0] M_AN  = 13'h00F0;
    localparam logic [12:0] M_DIG = 13'h000F;
    localparam logic [12:0] M_ALL = 13'h1FFF;
    localparam logic [3:0]  AN_TBL [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef struct {
        int          cyc;
        string       name;
        logic [12:0] val;
        logic [12:0] mask;
    } exp_t;

    exp_t q[$];
    int   ack_q[$];
    exp_t e;

    seg_scan_driver #(.CLK_DIV(8)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
        .lamp_test(lamp_test), .bright(bright), .load_ack(load_ack),
        .D(D), .C(C), .B(B), .A(A), .LT(LT), .RBI(RBI), .BI(BI),
        .an_n(an_n), .frame(frame)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign o = {load_ack, frame, LT, RBI, BI, an_n, D, C, B, A};

    function automatic logic [12:0] mk(input logic ack, frm, lt, rbi, bi,
                                       input logic [3:0] an, dig);
        return {ack, frm, lt, rbi, bi, an, dig};
    endfunction

    task automatic push(input int c, input string n, input logic [12:0] v, input logic [12:0] m);
        exp_t x;
        int   i;
        x.cyc = c; x.name = n; x.val = v; x.mask = m;
        i = 0;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, x);
    endtask

    // Frame starting at state-cycle f: pulse at f, slot j visible f+1+8j .. f+8+8j.
    task automatic exp_frame(input int f, input logic [15:0] v, input int nslots);
        push(f, $sformatf("frame_pulse_%0d", f), mk(0, 1, 0, 0, 0, 4'h0, 4'h0), M_FRM);
        for (int j = 0; j < nslots; j++) begin
            int          ix;
            logic [12:0] ev;
            ix = 3 - j;
            ev = mk(0, 0, 1, 1, 1, AN_TBL[j], v[ix*4 +: 4]);
            push(f + 1 + 8*j, $sformatf("f%0d_slot%0d_first", f, j), ev, M_AN | M_BI | M_DIG);
            push(f + 8 + 8*j, $sformatf("f%0d_slot%0d_last", f, j), ev, M_AN | M_BI | M_DIG);
        end
    endtask

    task automatic exp_rbi(input int c, input logic r);
        push(c, $sformatf("rbi_%0d", c), mk(0, 0, 0, r, 0, 4'h0, 4'h0), M_RBI);
    endtask

    task automatic exp_pwm(input int c, input logic [3:0] an, input logic bi);
        push(c, $sformatf("pwm_%0d", c), mk(0, 0, 0, 0, bi, an, 4'h0), M_AN | M_BI);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic strobe(input int c, input logic [15:0] v);
        at_cyc(c);
        bcd_in = v;
        load   = 1'b1;
        at_cyc(c + 1);
        load   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (load_ack === 1'b1) begin
            checks++;
            if (ack_q.size() != 0 && ack_q[0] == cyc) void'(ack_q.pop_front());
            else begin
                errors++;
                $display("FAIL unexpected_load_ack cyc=%0d got=1 exp=0", cyc);
            end
        end
        while (ack_q.size() != 0 && ack_q[0] < cyc) begin
            checks++; errors++;
            $display("FAIL missed_load_ack cyc=%0d got=0 exp=1", ack_q.pop_front());
        end
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s stale at cyc=%0d (due %0d)", e.name, cyc, e.cyc);
            end else if ((o & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h mask=%h", e.name, cyc, o & e.mask,
                         e.val & e.mask, e.mask);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load = 1'b0; bcd_in = '0; blank_lz = 1'b0; lamp_test = 1'b0; bright = 3'd7;
        push(2, "reset_state", mk(0, 0, 1, 1, 0, 4'b1111, 4'h0), M_ALL);
        push(3, "first_slot", mk(0, 0, 1, 1, 1, 4'b0111, 4'h0), M_ALL);
        at_cyc(2);
        rst = 1'b0;

        // Basic commit at first frame boundary, then 1,2,3,4 scanned out.
        ack_q.push_back(34);
        push(33, "pre_boundary", mk(0, 0, 1, 1, 1, 4'b1110, 4'h0), M_ALL);
        push(34, "no_tear", mk(1, 1, 1, 1, 1, 4'b1110, 4'h0), M_ALL);
        push(35, "pulses_drop", mk(0, 0, 0, 0, 0, 4'h0, 4'h0), M_ACK | M_FRM);
        exp_frame(34, 16'h1234, 4);
        strobe(5, 16'h1234);

        // Leading-zero blanking.
        at_cyc(40);
        blank_lz = 1'b1;
        ack_q.push_back(66);
        exp_frame(66, 16'h0045, 4);
        exp_rbi(67, 0); exp_rbi(74, 0); exp_rbi(75, 0); exp_rbi(82, 0);
        exp_rbi(83, 1); exp_rbi(90, 1); exp_rbi(91, 1); exp_rbi(98, 1);
        strobe(40, 16'h0045);

        ack_q.push_back(98);
        exp_frame(98, 16'h0000, 4);
        exp_rbi(99, 0); exp_rbi(115, 0); exp_rbi(122, 0); exp_rbi(123, 1); exp_rbi(130, 1);
        strobe(70, 16'h0000);

        // Dimming: bright=1 lights prescaler 0..1 only.
        at_cyc(130);
        bright = 3'd1;
        exp_pwm(131, 4'b0111, 1); exp_pwm(132, 4'b0111, 1);
        exp_pwm(133, 4'b1111, 0); exp_pwm(138, 4'b1111, 0);
        exp_pwm(155, 4'b1110, 1); exp_pwm(156, 4'b1110, 1);
        exp_pwm(157, 4'b1111, 0); exp_pwm(161, 4'b1111, 0);

        // Overwrite mid-frame and load coincident with the boundary.
        at_cyc(162);
        bright   = 3'd7;
        blank_lz = 1'b0;
        ack_q.push_back(194);
        ack_q.push_back(226);
        push(194, "no_tear2", mk(0, 0, 0, 0, 0, 4'h0, 4'h0), M_DIG);
        exp_frame(194, 16'h2222, 4);
        exp_frame(226, 16'h3333, 2);
        strobe(170, 16'h1111);
        strobe(175, 16'h2222);
        strobe(193, 16'h3333);

        // Lamp test mid-slot, dimmed to prove the override.
        at_cyc(230);
        push(231, "lamp_on", mk(0, 0, 0, 0, 1, 4'b0000, 4'h0), M_LT | M_AN | M_BI);
        push(232, "lamp_hold", mk(0, 0, 0, 0, 1, 4'b0000, 4'h0), M_LT | M_AN | M_BI);
        push(233, "lamp_off", mk(0, 0, 1, 0, 1, 4'b0111, 4'h3), M_LT | M_AN | M_BI | M_DIG);
        lamp_test = 1'b1;
        bright    = 3'd0;
        at_cyc(232);
        lamp_test = 1'b0;
        bright    = 3'd7;

        // Reset with a pending value: no ack, blank display afterwards.
        strobe(240, 16'h4444);
        at_cyc(250);
        push(251, "rst_vals", mk(0, 0, 1, 1, 0, 4'b1111, 4'h0), M_ALL);
        push(252, "rst_hold", mk(0, 0, 1, 1, 0, 4'b1111, 4'h0), M_ALL);
        push(253, "post_rst", mk(0, 0, 1, 1, 1, 4'b0111, 4'h0), M_ALL);
        push(284, "post_rst_frame", mk(0, 1, 0, 0, 0, 4'h0, 4'h0), M_ACK | M_FRM);
        push(285, "pending_dropped", mk(0, 0, 0, 0, 1, 4'b0111, 4'h0), M_AN | M_BI | M_DIG);
        rst = 1'b1;
        at_cyc(252);
        rst = 1'b0;

        at_cyc(300);
        while (q.size() != 0) begin
            e = q.pop_front();
            errors++;
            $display("FAIL %s never_checked due=%0d", e.name, e.cyc);
        end
        while (ack_q.size() != 0) begin
            errors++;
            $display("FAIL load_ack_never_seen due=%0d", ack_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
